load_store_unit: RTL and testbench

// - Sits between the core's execute stage and Data_Mem (clk, WE, A[31:0], WD[31:0], RD[31:0]; sync write, async read).
// - Accepts byte-addressed RV32I loads and stores: LB/LH/LW/LBU/LHU and SB/SH/SW.
// - Translates each request into word accesses on Data_Mem.
// - Implements SB/SH as a 2-cycle read-modify-write. Sign/zero-extends load data.
// - Flags misaligned, out-of-range and bad-funct3 requests without touching memory.

---
 rtl/load_store_unit_pkg.sv | 62 ++++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes, FSM states,
// request legality and store lane merging.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_MERGE  = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic req_is_bad(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [29:0] mem_words
    );
        logic bad;
        bad = (addr[31:2] >= mem_words);
        case (f3)
            F3_H, F3_HU: bad = bad | addr[0];
            F3_W:        bad = bad | (addr[1:0] != 2'b00);
            F3_B, F3_BU: bad = bad;
            default:     bad = 1'b1;
        endcase
        // Stores only exist as B/H/W; the unsigned encodings are illegal there.
        if (we && (f3 >= 3'b011)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [15:0] wdata,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [31:0] m;
        m = word;
        if (f3 == F3_B) begin
            case (off)
                2'd0:    m[7:0]   = wdata[7:0];
                2'd1:    m[15:8]  = wdata[7:0];
                2'd2:    m[23:16] = wdata[7:0];
                default: m[31:24] = wdata[7:0];
            endcase
        end else if (off[1]) begin
            m[31:16] = wdata;
        end else begin
            m[15:0] = wdata;
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a memory word and extends it to 32 bits.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off)
            2'd0:    byte_sel = mem_rd[7:0];
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            default: byte_sel = mem_rd[31:24];
        endcase
        half_sel = byte_off[1] ? mem_rd[31:16] : mem_rd[15:0];

        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_W:    rdata = mem_rd;
            F3_BU:   rdata = {24'd0, byte_sel};
            F3_HU:   rdata = {16'd0, half_sel};
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide Data_Mem; sub-word stores are done
// as a read followed by a merged write.
//
// state    | meaning
// S_IDLE   | ready for a request
// S_ACCESS | memory read (loads, SB/SH) or word write (SW)
// S_MERGE  | write back the merged word for SB/SH
// S_RESP   | one-cycle completion pulse
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic [31:0] load_data;
    logic        req_bad;

    lsu_load_align u_load_align (
        .mem_rd   (mem_RD),
        .byte_off (off_q),
        .funct3   (funct3_q),
        .rdata    (load_data)
    );

    assign req_bad = req_is_bad(req_we, req_funct3, req_addr, MEM_WORDS_W);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_a_d     = mem_a_q;
        mem_wd_d    = mem_wd_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata[15:0];
                    mem_a_d     = {2'b00, req_addr[31:2]};
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = req_bad;
                    if (req_bad) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ACCESS;
                        if (req_we && (req_funct3 == F3_W)) begin
                            mem_wd_d = req_wdata;
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rsp_rdata_d = load_data;
                    state_d     = S_RESP;
                end else if (funct3_q == F3_W) begin
                    state_d = S_RESP;
                end else begin
                    mem_wd_d = merge_store(mem_RD, wdata_q, off_q, funct3_q);
                    state_d  = S_MERGE;
                end
            end
            S_MERGE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        mem_we_d    = (state_d == S_MERGE) ||
                      ((state_d == S_ACCESS) && we_d && (funct3_d == F3_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 16'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= 32'd0;
            mem_wd_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    // Reset must also block the write on the edge it arrives, or an aborted RMW lands in memory.
    assign mem_WE    = mem_we_q & ~rst;
    assign mem_A     = mem_a_q;
    assign mem_WD    = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with an inline word memory and a byte-level reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_WE     (mem_WE),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dmem [64];
    assign mem_RD = dmem[mem_A[5:0]];
    always @(posedge clk) if (mem_WE) dmem[mem_A[5:0]] <= mem_WD;

    logic [7:0]  ref_mem [256];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = -1;
    int          rsp_cyc = -1;
    int          we_cyc = -1;
    int          busy_end = -2;
    bit          chk_en = 1'b0;
    logic [31:0] exp_rdata, exp_wa, exp_wd;
    logic        exp_err;
    logic [31:0] last_rdata, last_wa, last_wd;
    logic        last_err;
    int          wr_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expectations the model set up for the current request.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(!((cyc >= acc_cyc) && (cyc <= busy_end))));
            check("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_cyc));
            if (cyc == rsp_cyc) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
            check("mem_WE", 32'(mem_WE), 32'(cyc == we_cyc));
            if (mem_WE) begin
                wr_count++;
                last_wa = mem_A;
                last_wd = mem_WD;
                if (cyc == we_cyc) begin
                    check("mem_A", mem_A, exp_wa);
                    check("mem_WD", mem_WD, exp_wd);
                end
            end
        end
    end

    function automatic bit model_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if ((addr % sz) != 0) return 1'b1;
        if ((addr / 4) >= 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit abort);
        bit          bad;
        int          sz;
        int          lat;
        int          n;
        int          a;
        logic [31:0] v;
        bad = model_bad(we, f3, addr);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lat = bad ? 1 : ((we && sz < 4) ? 3 : 2);
        a   = int'(addr);
        @(negedge clk);
        exp_err   = bad;
        exp_rdata = 32'd0;
        if (!bad && !we) begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
            if (!f3[2] && sz < 4 && v[8 * sz - 1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
            exp_rdata = v;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
            req_valid = 1'b0;
            return;
        end
        acc_cyc  = cyc + 1;
        rsp_cyc  = abort ? -1 : acc_cyc + lat - 1;
        we_cyc   = (!bad && we && !abort) ? acc_cyc + lat - 2 : -1;
        busy_end = abort ? acc_cyc + 1 : rsp_cyc;
        if (!bad && we && !abort) begin
            for (int i = 0; i < sz; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
            exp_wa = addr >> 2;
            exp_wd = ref_word(a & ~3);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (abort) begin
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            n = 0;
            while (cyc <= rsp_cyc && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time got 100000 expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_WE", 32'(mem_WE), 32'd0);
        check("rst_mem_A", mem_A, 32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        chk_en = 1'b1;

        do_req(1'b1, 3'b010, 32'h28, 32'hDEADBEEF, 1'b0);
        check("sw28_wa", last_wa, 32'd10);
        check("sw28_wd", last_wd, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h28, 32'h0, 1'b0);
        check("lw28", last_rdata, 32'hDEADBEEF);

        do_req(1'b1, 3'b000, 32'h29, 32'h000000AA, 1'b0);
        check("sb29_wd", last_wd, 32'hDEADAAEF);
        do_req(1'b0, 3'b100, 32'h29, 32'h0, 1'b0);
        check("lbu29", last_rdata, 32'h000000AA);
        do_req(1'b0, 3'b000, 32'h29, 32'h0, 1'b0);
        check("lb29", last_rdata, 32'hFFFFFFAA);

        do_req(1'b1, 3'b010, 32'h50, 32'hCAFEBABE, 1'b0);
        do_req(1'b1, 3'b001, 32'h52, 32'h00001234, 1'b0);
        check("word20_mem", dmem[20], 32'h1234BABE);
        check("word20_model", ref_word(32'h50), 32'h1234BABE);
        do_req(1'b0, 3'b001, 32'h52, 32'h0, 1'b0);
        check("lh52", last_rdata, 32'h00001234);
        do_req(1'b0, 3'b001, 32'h50, 32'h0, 1'b0);
        check("lh50", last_rdata, 32'hFFFFBABE);
        do_req(1'b0, 3'b101, 32'h50, 32'h0, 1'b0);
        check("lhu50", last_rdata, 32'h0000BABE);

        do_req(1'b0, 3'b010, 32'h2A, 32'h0, 1'b0);
        check("err_lw2a", 32'(last_err), 32'd1);
        do_req(1'b1, 3'b001, 32'h2B, 32'h5555, 1'b0);
        check("err_sh2b", 32'(last_err), 32'd1);
        do_req(1'b1, 3'b010, 32'h100, 32'h12345678, 1'b0);
        check("err_sw100", 32'(last_err), 32'd1);
        do_req(1'b0, 3'b011, 32'h28, 32'h0, 1'b0);
        check("err_f3_011", 32'(last_err), 32'd1);
        check("err_f3_rdata", last_rdata, 32'd0);
        check("write_count", 32'(wr_count), 32'd4);

        do_req(1'b1, 3'b000, 32'h28, 32'h00000011, 1'b1);
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        check("abort_word10", dmem[10], 32'hDEADAAEF);
        check("abort_write_count", 32'(wr_count), 32'd4);
        do_req(1'b0, 3'b010, 32'h28, 32'h0, 1'b0);
        check("lw28_after_abort", last_rdata, 32'hDEADAAEF);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
